// File: rtl/demux_stream_1to4.sv
// Registered 1-to-4 stream demultiplexer: each word goes to one of four
// one-entry channel buffers, chosen by explicit select or a round-robin pointer.
module demux_stream_1to4 #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       select,
    input  logic             rr_en,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       rr_ptr
);

    localparam int unsigned NCH = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    ch_state_t        state_q [NCH];
    ch_state_t        state_d [NCH];
    logic [WIDTH-1:0] data_q  [NCH];
    logic [WIDTH-1:0] data_d  [NCH];
    logic [1:0]       rr_q;
    logic [1:0]       rr_d;
    logic [1:0]       dest;
    logic             accept;

    // Destination and handshake are combinational so a draining channel can reload with no bubble.
    assign dest     = rr_en ? rr_q : select;
    assign in_ready = ~out_valid[dest] | out_ready[dest];
    assign accept   = in_valid & in_ready;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            out_valid[k] = (state_q[k] == FULL);
        end
    end

    assign out0   = data_q[0];
    assign out1   = data_q[1];
    assign out2   = data_q[2];
    assign out3   = data_q[3];
    assign rr_ptr = rr_q;

    // Per-channel EMPTY/FULL next state; a load to a FULL channel overrides its drain.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
        end
        rr_d = rr_q;

        for (int k = 0; k < NCH; k++) begin
            case (state_q[k])
                EMPTY: begin
                    if (accept && (dest == 2'(k))) begin
                        state_d[k] = FULL;
                        data_d[k]  = in_data;
                    end
                end
                FULL: begin
                    if (accept && (dest == 2'(k))) begin
                        data_d[k] = in_data;
                    end else if (out_ready[k]) begin
                        state_d[k] = EMPTY;
                    end
                end
                default: state_d[k] = EMPTY;
            endcase
        end

        if (accept && rr_en) begin
            rr_d = rr_q + 2'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
            rr_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            rr_q <= rr_d;
        end
    end

endmodule

// File: tb/tb_demux_stream_1to4.sv
// Bench for demux_stream_1to4: directed scenarios plus random traffic,
// checked against a channel-level buffer model.
module tb_demux_stream_1to4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] select;
    logic       rr_en;
    logic [1:0] out0, out1, out2, out3;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] rr_ptr;

    int errors = 0;
    int checks = 0;

    // Reference model: a held word and full flag per channel, plus the pointer.
    bit       vm [4];
    bit [1:0] dm [4];
    int       rr_m;

    logic [1:0] outs [4];
    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;

    demux_stream_1to4 #(.WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .select    (select),
        .rr_en     (rr_en),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, compare against model, then advance model at posedge.
    task automatic step(input logic r, input logic v, input logic [1:0] d,
                        input logic [1:0] s, input logic rr, input logic [3:0] rdy);
        int  dst;
        bit  exp_rdy;
        bit  acc;
        logic [3:0] vbits;
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; select = s; rr_en = rr; out_ready = rdy;
        #1;
        dst     = rr ? rr_m : int'(s);
        exp_rdy = !vm[dst] || rdy[dst];
        for (int k = 0; k < 4; k++) vbits[k] = vm[k];
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, vbits);
        check("rr_ptr", rr_ptr, rr_m);
        for (int k = 0; k < 4; k++) begin
            if (vm[k]) check($sformatf("out%0d", k), outs[k], dm[k]);
        end
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 4; k++) begin vm[k] = 0; dm[k] = 0; end
            rr_m = 0;
        end else begin
            acc = v && exp_rdy;
            for (int k = 0; k < 4; k++) begin
                if (acc && dst == k) begin vm[k] = 1; dm[k] = d; end
                else if (rdy[k]) vm[k] = 0;
            end
            if (acc && rr) rr_m = (rr_m + 1) % 4;
        end
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = 0; select = 0; rr_en = 0; out_ready = 0;
        for (int k = 0; k < 4; k++) begin vm[k] = 0; dm[k] = 0; end
        rr_m = 0;

        // Reset
        step(1, 0, 0, 0, 0, 4'b0000);
        step(1, 0, 0, 0, 0, 4'b0000);
        #1;
        check("rst_valid", out_valid, 4'b0000);
        check("rst_out0", out0, 0);
        check("rst_out1", out1, 0);
        check("rst_out2", out2, 0);
        check("rst_out3", out3, 0);
        check("rst_rr", rr_ptr, 0);
        check("rst_in_ready", in_ready, 1);

        // Select route to ch2
        step(0, 1, 2'b11, 2, 0, 4'b1111);
        #1;
        check("sel_valid", out_valid, 4'b0100);
        check("sel_out2", out2, 2'b11);
        step(0, 0, 0, 2, 0, 4'b1111);
        #1;
        check("sel_drained", out_valid, 4'b0000);

        // Backpressure on ch1
        step(0, 1, 2'b01, 1, 0, 4'b1101);
        step(0, 1, 2'b10, 1, 0, 4'b1101);
        #1;
        check("bp_hold_out1", out1, 2'b01);
        check("bp_hold_valid1", out_valid[1], 1);
        step(0, 1, 2'b10, 1, 0, 4'b1111);
        #1;
        check("bp_new_out1", out1, 2'b10);
        check("bp_new_valid1", out_valid[1], 1);

        // Round robin over five words
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 2'(i % 4), 0, 1, 4'b1111);
            #1;
            check($sformatf("rr_valid%0d", i), out_valid, 4'b0001 << (i % 4));
            check($sformatf("rr_data%0d", i), outs[i % 4], i % 4);
            check($sformatf("rr_ptr%0d", i), rr_ptr, (i + 1) % 4);
        end

        // Drain and reload ch0 in the same cycle
        step(0, 1, 2'b01, 0, 0, 4'b1111);
        step(0, 1, 2'b10, 0, 0, 4'b0001);
        #1;
        check("reload_valid0", out_valid[0], 1);
        check("reload_out0", out0, 2'b10);

        // Reset with ch3 stalled
        step(0, 1, 2'b11, 3, 0, 4'b0000);
        #1;
        check("pre_rst_valid3", out_valid[3], 1);
        step(1, 0, 0, 0, 0, 4'b0000);
        #1;
        check("midrst_valid", out_valid, 4'b0000);
        check("midrst_rr", rr_ptr, 0);
        step(0, 0, 0, 0, 0, 4'b0000);
        #1;
        check("midrst_gone", out_valid, 4'b0000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0), 1'($urandom), 2'($urandom), 2'($urandom),
                 ($urandom_range(0, 3) != 0), 4'($urandom));
        end
        step(0, 0, 0, 0, 0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
